// File: rtl/mem_phase_seq.sv
// mem_phase_seq: request-side sequencer for the dual-fetch instruction/data RAM.
// One accepted request walks the RAM through i1re -> i2re -> dre -> gwe, then
// presents both fetched instructions and the data read result with a one-cycle
// rsp_valid pulse. gwe is also the core's global write enable.
// Optional feature macro: MEMSEQ_WR_FORWARD_EN (a read+write request returns the
// written data instead of the RAM's pre-write contents).
module mem_phase_seq #(
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [15:0]       req_i1addr,
    input  logic [15:0]       req_i2addr,
    input  logic [15:0]       req_daddr,
    input  logic              req_dre,
    input  logic              req_dwe,
    input  logic [DATA_W-1:0] req_din,
    output logic              i1re,
    output logic              i2re,
    output logic              dre,
    output logic              gwe,
    output logic [15:0]       i1addr,
    output logic [15:0]       i2addr,
    output logic [15:0]       daddr,
    output logic [DATA_W-1:0] din,
    output logic              dwe,
    input  logic [15:0]       i1out,
    input  logic [15:0]       i2out,
    input  logic [DATA_W-1:0] dout,
    output logic              rsp_valid,
    output logic [15:0]       rsp_i1,
    output logic [15:0]       rsp_i2,
    output logic [DATA_W-1:0] rsp_dout
);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        P1   = 3'd1,
        P2   = 3'd2,
        P3   = 3'd3,
        P4   = 3'd4
    } state_t;

    state_t state;

    // Request fields needed after the accept edge. The first fetch address is
    // driven straight onto i1addr at accept, so it needs no holding copy.
    logic [15:0]       lat_i2addr;
    logic [15:0]       lat_daddr;
    logic              lat_dre;
    logic              lat_dwe;
    logic [DATA_W-1:0] lat_din;

    logic              accept;
    logic [DATA_W-1:0] dout_sel;

    // req_ready is only high in IDLE and P4, so this is the only accept point.
    assign accept = req_valid & req_ready;

`ifdef MEMSEQ_WR_FORWARD_EN
    // A request carries a single data address, so read+write always targets
    // the same word; return the value being written.
    assign dout_sel = (lat_dre & lat_dwe) ? lat_din : dout;
`else
    // The RAM reads before it writes, so dout is the pre-write contents.
    assign dout_sel = dout;
`endif

    // Hold the accepted request; inputs changing while busy are not observed.
    always_ff @(posedge clk) begin
        if (accept) begin
            lat_i2addr <= req_i2addr;
            lat_daddr  <= req_daddr;
            lat_dre    <= req_dre;
            lat_dwe    <= req_dwe;
            lat_din    <= req_din;
        end
    end

    // Phase sequencer with registered strobes, addresses and response capture.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            i1re      <= 1'b0;
            i2re      <= 1'b0;
            dre       <= 1'b0;
            gwe       <= 1'b0;
            dwe       <= 1'b0;
            req_ready <= 1'b1;
            rsp_valid <= 1'b0;
            rsp_i1    <= '0;
            rsp_i2    <= '0;
            rsp_dout  <= '0;
            i1addr    <= '0;
            i2addr    <= '0;
            daddr     <= '0;
            din       <= '0;
        end else begin
            rsp_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        state     <= P1;
                        i1re      <= 1'b1;
                        i1addr    <= req_i1addr;
                        req_ready <= 1'b0;
                    end
                end
                P1: begin
                    state  <= P2;
                    i1re   <= 1'b0;
                    i2re   <= 1'b1;
                    i2addr <= lat_i2addr;
                end
                P2: begin
                    // i1out became valid after the P1 read; dre always fires
                    // because the RAM uses it to multiplex i2out.
                    state  <= P3;
                    i2re   <= 1'b0;
                    dre    <= 1'b1;
                    daddr  <= lat_daddr;
                    dwe    <= lat_dwe;
                    din    <= lat_din;
                    rsp_i1 <= i1out;
                end
                P3: begin
                    state     <= P4;
                    dre       <= 1'b0;
                    dwe       <= 1'b0;
                    gwe       <= 1'b1;
                    req_ready <= 1'b1;
                    rsp_i2    <= i2out;
                end
                P4: begin
                    gwe       <= 1'b0;
                    rsp_valid <= 1'b1;
                    if (lat_dre) begin
                        rsp_dout <= dout_sel;
                    end
                    if (req_valid) begin
                        // Back-to-back: start the next transaction with no gap.
                        state     <= P1;
                        i1re      <= 1'b1;
                        i1addr    <= req_i1addr;
                        req_ready <= 1'b0;
                    end else begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/mem_phase_seq.md
# mem_phase_seq

Request-side sequencer for the team's dual-fetch instruction/data block RAM. It accepts one bundled request from the core: two instruction-fetch addresses plus an optional data read or write. It then drives the RAM's fixed four-phase strobe sequence (i1re → i2re → dre → gwe) and returns all three read results together with a single-cycle valid pulse. Its gwe output doubles as the core's global write enable, so it sets the core's commit cadence.

## Interface
- DATA_W, 16, data word width; must match the RAM's WORD_SIZE.
- clk  in  1  single clock; also drives the RAM's idclk.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  1  core presents a request.
- req_ready  out  1  sequencer can accept a request this cycle.
- req_i1addr  in  16  first instruction fetch address.
- req_i2addr  in  16  second instruction fetch address.
- req_daddr  in  16  data address.
- req_dre  in  1  data read requested.
- req_dwe  in  1  data write requested; may be set together with req_dre.
- req_din  in  DATA_W  write data.
- i1re, i2re, dre, gwe  out  1 each  RAM phase strobes.
- i1addr, i2addr, daddr  out  16 each  RAM addresses.
- din  out  DATA_W  RAM write data.
- dwe  out  1  RAM data write enable.
- i1out, i2out  in  16 each  RAM instruction outputs.
- dout  in  DATA_W  RAM data output.
- rsp_valid  out  1  one-cycle pulse: response registers updated.
- rsp_i1, rsp_i2  out  16 each  fetched instructions.
- rsp_dout  out  DATA_W  data read result.

## Operation
- States: IDLE, P1, P2, P3, P4. Exactly one state is active at a time; rst forces IDLE.
- IDLE: strobes 0; req_ready=1. On req_valid, latch the request and go to P1.
- P1: i1re=1; i1addr = latched i1addr. Go to P2.
- P2: i2re=1; i2addr = latched i2addr. Go to P3.
- P3: dre=1 regardless of req_dre, because the RAM needs dre to time-multiplex i2out. daddr = latched daddr. dwe = latched dwe and is asserted in P3 only. din = latched din. Go to P4.
- P4: gwe=1; dwe=0; req_ready=1.
  - On req_valid, latch the new request and go to P1, giving back-to-back 4-cycle transactions.
  - Otherwise go to IDLE.
- Capture:
  - rsp_i1 is registered from i1out at the P2→P3 edge.
  - rsp_i2 is registered from i2out at the P3→P4 edge.
  - rsp_dout is registered from dout at the P4 exit edge, but only if the latched dre=1; otherwise it holds its previous value.
  - rsp_valid=1 for exactly the one cycle after P4.
- Read and write to the same address in one request: the RAM reads before it writes, so rsp_dout is the old contents, except as given under Configuration.
- Address outputs hold their last driven value when their strobe is low. Addresses are 16 bits, passed through with no arithmetic.

## Timing
- Reset values: state IDLE, all strobes 0, dwe 0, req_ready 1, rsp_valid 0, rsp_* 0, address and din outputs 0.
- Accept edge E0 → P1 in cycle 1, P4 in cycle 4, rsp_valid in cycle 5. Latency is 5 cycles.
- Sustained throughput is one request per 4 cycles. gwe is high 1 cycle in 4 while busy.
- rst asserted mid-transaction: next cycle is IDLE with no strobes. A pending rsp_valid is suppressed. rsp_* are cleared to 0. No partial write occurs unless P3 was already active on the reset edge.
- req_valid is sampled only when req_ready=1. Changes in the request inputs while busy are ignored.

## Configuration
- MEMSEQ_WR_FORWARD_EN defined: when the latched request has dre=1 and dwe=1 with the same address, rsp_dout returns the latched din (write-forwarded).
- MEMSEQ_WR_FORWARD_EN undefined: rsp_dout returns the RAM's pre-write value.

## Test plan
- Reset: assert rst 2 cycles → all strobes 0, req_ready=1, rsp_valid=0, rsp_*=0.
- Single read: memory_i[0x10]=0xA001, memory_i[0x11]=0xB002, memory_d[0x20]=0x1234. Request i1=0x10, i2=0x11, d=0x20, dre=1 → strobes fire in cycles 1-4 in order. Cycle 5: rsp_valid=1, rsp_i1=0xA001, rsp_i2=0xB002, rsp_dout=0x1234.
- Write then read-same: memory_d[0x30]=0x0BAD. Request dre=1, dwe=1, daddr=0x30, din=0xBEEF → dwe high only in P3. Result: rsp_dout=0x0BAD without the macro, 0xBEEF with it. A following read of 0x30 returns 0xBEEF.
- Back-to-back: hold req_valid for 3 requests → gwe pulses in cycles 4, 8, 12; rsp_valid in cycles 5, 9, 13; no idle gaps.
- Reset mid-op: rst in P2 → no dre, dwe or gwe afterwards; no rsp_valid; IDLE the following cycle; the next request completes normally.
- No data read: dre=0 request after a read returning 0x1234 → rsp_dout stays 0x1234, while rsp_i1 and rsp_i2 update.
